// File: rtl/isqrt_seq.sv
// Sequential integer square root: restoring digit-by-digit method, one root
// bit per clock, fixed W/2-cycle latency, start/busy/done handshake.
module isqrt_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           start,
  input  logic [W-1:0]   n,
  output logic           busy,
  output logic           done,
  output logic [W/2-1:0] root,
  output logic [W/2:0]   rem
);

  localparam int unsigned H  = W / 2;
  localparam int unsigned CW = (H > 1) ? $clog2(H) : 1;

  if (((W % 2) != 0) || (W < 4)) begin : g_cfg_check
    $error("isqrt_seq: W must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    x;
  // Only the low H bits of the partial remainder are ever consumed before the
  // final step; the full-width final remainder goes straight to rem.
  logic [H-1:0]    r;
  logic [H-1:0]    q;
  logic [CW-1:0]   cnt;
  logic [H+1:0]    rs;
  logic [H+1:0]    t;
  logic [H:0]      r_next;
  logic [H-1:0]    q_next;
  logic            accept;

  // One iteration: trial-subtract {q,01} from the remainder shifted by two
  // radicand bits; keep the difference and set the root bit if non-negative.
  always_comb begin
    rs     = {r, x[W-1:W-2]};
    t      = rs - {q, 2'b01};
    q_next = {q[H-2:0], ~t[H+1]};
    r_next = t[H+1] ? rs[H:0] : t[H:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs; start is honoured in IDLE and DONE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        state_next = start ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, publish result on last step.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      x    <= '0;
      r    <= '0;
      q    <= '0;
      cnt  <= '0;
      root <= '0;
      rem  <= '0;
    end else if (accept) begin
      x   <= n;
      r   <= '0;
      q   <= '0;
      cnt <= CW'(H - 1);
    end else if (state == CALC) begin
      x   <= x << 2;
      r   <= r_next[H-1:0];
      q   <= q_next;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        root <= q_next;
        rem  <= r_next;
      end
    end
  end

endmodule

// File: doc/isqrt_seq.md
# isqrt_seq

Parametrised sequential integer square-root unit: accepts a W-bit unsigned radicand on a start pulse and returns the W/2-bit floor root and its remainder. It uses the digit-by-digit (restoring) method, one root bit per clock, so latency is W/2 cycles regardless of operand value. It replaces the fixed 8-bit odd-number-subtraction unit, which had data-dependent latency and no remainder. It sits beside the datapath's arithmetic units and uses a start/busy/done handshake.

## Interface
- W, default 8: radicand width; must be even and ≥ 4. An odd or smaller value is a configuration error; `$error` at elaboration.
- clk  in  1  rising-edge clock for all state.
- rstN  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled on rising clk; honoured only when not busy.
- n  in  W  unsigned radicand; sampled on the same edge that accepts start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; root and rem are valid and newly updated.
- root  out  W/2  floor(sqrt(n)), registered.
- rem  out  W/2+1  n − root², registered; maximum value is 2·root.

## Operation
- FSM states:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: one-cycle result-strobe state, which also accepts start.
- Internal registers:
  - shift register x (W bits) holding the radicand.
  - partial remainder r (W/2+2 bits).
  - partial root q (W/2 bits).
  - iteration counter cnt, ⌈log2(W/2)⌉ bits.
- Accept (IDLE or DONE, start=1):
  - x←n, r←0, q←0, cnt←W/2−1.
  - state→CALC, busy←1.
- Each CALC cycle:
  - t = {r[W/2−1:0], x[W−1:W−2]} − {q, 2'b01}, evaluated W/2+2 bits wide.
  - If t is non-negative (MSB 0): r←t, q←{q[W/2−2:0],1}.
  - Otherwise: r←{r[W/2−1:0], x[W−1:W−2]}, q←{q[W/2−2:0],0}.
  - x←x<<2; cnt←cnt−1.
- Last CALC cycle (cnt==0), computed with that cycle's values:
  - root←final q and rem←final r[W/2:0].
  - done←1, busy←0, state→DONE.
- DONE:
  - done deasserts on the next edge; state→IDLE unless start=1, in which case a new operation is accepted (back-to-back).
- root and rem change only on the done edge. They hold their last result through IDLE and through the following CALC phase.
- start while busy is ignored, with no queueing and no effect on the current operation; n is don't-care then.
- Reset, asynchronous and at any time including mid-CALC:
  - state=IDLE; busy=0, done=0, root=0, rem=0; internal registers cleared.
  - Any in-flight operation is discarded with no done pulse.
- Arithmetic is unsigned throughout; no overflow is possible with the widths above.

## Timing
- Start accepted at edge E0 → busy high after E0.
- Iterations occur at edges E1..E(W/2).
- busy falls and done rises after E(W/2); done falls after E(W/2+1).
- Latency from the accepting edge to done is exactly W/2 clocks, independent of n.
- Maximum throughput: one result per W/2+1 clocks, using start asserted during the DONE cycle.
- Outputs are registered; there is no combinational path from start or n to any output.

## Test plan
- Reset, then W=8, n=0 → done 4 clocks after accept; root=0, rem=0; busy high exactly 4 cycles.
- W=8, sweep n=0..255 against a model → root=floor(sqrt(n)), rem=n−root²; spot checks: 144→12/0, 143→11/22, 255→15/30, 1→1/0.
- W=8, n=200 accepted, then start with n=9 pulsed while busy → single done, root=14, rem=4; no second operation.
- W=8, start held high continuously with n=100 → done every 5 clocks; root=10, rem=0 each time; busy low only during DONE cycles.
- W=8, rstN pulsed low mid-CALC (2 clocks after accept of n=255) → busy/done/root/rem all 0 immediately; no done pulse; the next start with n=16 gives 4/0.
- W=16, n=65535 → done after 8 clocks, root=255, rem=510; n=40000 → root=200, rem=0.
